// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_HOLD_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arb_select.sv
// rtl/dmem_arb_select.sv - grant selection between CPU and debug ports
// Round-robin when DMEM_ARB_RR_EN is defined, else CPU priority with a starvation counter.
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   c_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_t sel
);

`ifdef DMEM_ARB_RR_EN
  owner_t last;

  // On contention, favour whichever port did not win the previous grant.
  always_comb begin
    sel = OWN_CPU;
    if (c_req && d_req)
      sel = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    else if (d_req)
      sel = OWN_DBG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= OWN_DBG;
    else if (grant)
      last <= sel;
  end
`else
  logic [3:0] cnt;

  // CPU wins contention until the debug port has waited HOLD_MAX CPU grants.
  always_comb begin
    sel = OWN_CPU;
    if (c_req && d_req)
      sel = (cnt == 4'(HOLD_MAX)) ? OWN_DBG : OWN_CPU;
    else if (d_req)
      sel = OWN_DBG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 4'd0;
    else if (!d_req)
      cnt <= 4'd0;
    else if (grant)
      cnt <= (sel == OWN_DBG) ? 4'd0 : cnt + 4'd1;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single data memory
// Optional round-robin arbitration via DMEM_ARB_RR_EN; default is CPU priority with hold limit.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t state;
  owner_t owner;
  owner_t sel;
  logic   lat_we;
  logic   grant;

  assign grant = (state == IDLE) && (c_req || d_req);

  dmem_arb_select #(
    .HOLD_MAX(HOLD_MAX)
  ) u_select (
    .clk  (clk),
    .rst  (rst),
    .c_req(c_req),
    .d_req(d_req),
    .grant(grant),
    .sel  (sel)
  );

  // mem_addr/mem_din double as the latched request so they hold between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_CPU;
      lat_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= sel;
            if (sel == OWN_CPU) begin
              lat_we   <= c_we;
              mem_addr <= c_addr;
              mem_din  <= c_wdata;
            end else begin
              lat_we   <= d_we;
              mem_addr <= d_addr;
              mem_din  <= d_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rdata <= mem_dout;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the write strobe at once.
  assign mem_we  = (state == ACCESS) && lat_we;
  assign c_ack   = (state == RESP) && (owner == OWN_CPU);
  assign d_ack   = (state == RESP) && (owner == OWN_DBG);
  assign c_stall = c_req && !c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed testbench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

  logic       clk;
  logic       rst;
  logic       c_req, c_we, c_ack, c_stall;
  logic [7:0] c_addr, c_wdata;
  logic       d_req, d_we, d_ack;
  logic [7:0] d_addr, d_wdata;
  logic [7:0] rdata, mem_addr, mem_din, mem_dout;
  logic       mem_we;
  logic       mem_clr;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  logic exp_seq [10];

  dmem_arbiter u_dut (
    .clk     (clk),
    .rst     (rst),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ack   (c_ack),
    .c_stall (c_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .rdata   (rdata),
    .mem_addr(mem_addr),
    .mem_we  (mem_we),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One single-port transaction: request in cycle N, ACCESS in N+1, ack in N+2.
  task automatic txn(input int idx, input vec_t v);
    logic own_ack, oth_ack;
    @(negedge clk);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end
    #1;
    chk($sformatf("v%0d_stall_idle", idx), c_stall, !v.port);
    @(posedge clk); #1;
    chk($sformatf("v%0d_mem_we", idx), mem_we, v.we);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    if (v.we) chk($sformatf("v%0d_mem_din", idx), mem_din, v.wdata);
    chk($sformatf("v%0d_stall_access", idx), c_stall, !v.port);
    chk($sformatf("v%0d_ack_early", idx), {c_ack, d_ack}, 2'b00);
    @(posedge clk); #1;
    own_ack = v.port ? d_ack : c_ack;
    oth_ack = v.port ? c_ack : d_ack;
    chk($sformatf("v%0d_ack", idx), own_ack, 1'b1);
    chk($sformatf("v%0d_other_ack", idx), oth_ack, 1'b0);
    chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    chk($sformatf("v%0d_mem_we_resp", idx), mem_we, 1'b0);
    chk($sformatf("v%0d_stall_resp", idx), c_stall, 1'b0);
    c_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_ack_single", idx), {c_ack, d_ack}, 2'b00);
  endtask

  initial begin
    int n;
    vec_t v;

    rst = 1'b1; mem_clr = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    vecs[0] = '{1'b0, 1'b1, 8'h1F, 8'h07, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h1F, 8'h00, 8'h07};
    vecs[2] = '{1'b1, 1'b1, 8'h40, 8'hA5, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 8'h40, 8'h3C, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 1'b1, 8'h80, 8'h81, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h81};

`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 10; i++) exp_seq[i] = i[0];
`else
    for (int i = 0; i < 10; i++) exp_seq[i] = (i == 4 || i == 9);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_acks", {c_ack, d_ack}, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_din", mem_din, 8'h00);
    rst = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 8; i++) txn(i, vecs[i]);

    // Reset so the round-robin pointer restarts from "debug granted last".
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    c_we = 0; d_we = 0; c_addr = 8'h00; d_addr = 8'h00;
    c_req = 1'b1; d_req = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      @(posedge clk); #1;
      chk("ack_exclusive", c_ack & d_ack, 1'b0);
      if (c_ack || d_ack) begin
        chk($sformatf("grant%0d_is_dbg", n), d_ack, exp_seq[n]);
        n++;
      end
    end
    chk("contention_grants", n, 10);
    c_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Debug read whose request is withdrawn during ACCESS still completes.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("drop_mem_addr", mem_addr, 8'h40);
    @(posedge clk); #1;
    chk("drop_d_ack", d_ack, 1'b1);
    chk("drop_rdata", rdata, 8'h3C);
    @(posedge clk); #1;
    chk("drop_d_ack_once", d_ack, 1'b0);

    // Reset landing in ACCESS of a debug write to 0xFF.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'hFF; d_wdata = 8'h99;
    @(posedge clk); #1;
    chk("rstacc_mem_we_before", mem_we, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstacc_mem_we_async", mem_we, 1'b0);
    chk("rstacc_d_ack", d_ack, 1'b0);
    chk("rstacc_mem_addr", mem_addr, 8'h00);
    @(posedge clk); #1;
    chk("rstacc_mem_ff", mem[8'hFF], 8'h00);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstacc_no_ack", {c_ack, d_ack}, 2'b00);
    end
    v = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00};
    txn(8, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width.
REQ-002 Parameter DATA_W, default 8, data-memory word width.
REQ-003 Parameter HOLD_MAX, default 4, maximum consecutive CPU grants while the debug port waits (fixed-priority mode only); legal range 1..15.
REQ-004 The block SHALL use one clock, clk, and reset rst, which is asynchronous and active-high.
REQ-005 Ports, one per line:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-high reset.
- c_req  in  1  CPU access request; held until c_ack.
- c_we  in  1  CPU write (1) or read (0).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_ack  out  1  one-cycle CPU completion pulse.
- c_stall  out  1  c_req & ~c_ack; combinational CPU hold.
- d_req, d_we, d_addr, d_wdata, d_ack  same as the c_ ports, for the debug/loader port.
- rdata  out  DATA_W  read data, valid while c_ack or d_ack is high.
- mem_addr  out  ADDR_W  data-memory address.
- mem_we  out  1  data-memory write enable.
- mem_din  out  DATA_W  data-memory write data.
- mem_dout  in  DATA_W  data-memory read data; combinational from mem_addr.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-007 In IDLE, when c_req or d_req is high at a rising edge, the block SHALL latch owner, we, addr and wdata from the selected port and go to ACCESS; with no request it stays in IDLE.
REQ-008 In ACCESS, mem_addr/mem_din SHALL come from the latched values, mem_we SHALL equal the latched we, and the next edge SHALL capture mem_dout into rdata and go to RESP.
REQ-009 In RESP, the owner's ack SHALL be high for exactly one cycle; the next state SHALL be IDLE.
REQ-010 Latency: request sampled at edge N, ack high in cycle N+2, next grant no earlier than edge N+3 (3-cycle throughput).
REQ-011 Outside ACCESS, mem_we SHALL be 0, and mem_addr/mem_din SHALL hold the last latched values.
REQ-012 Requests SHALL be sampled only in IDLE; deasserting req after it is latched SHALL NOT abort the transaction; port inputs SHALL be ignored after latching.
REQ-013 A requester holding req high in the cycle after its ack SHALL be treated as a new request.
REQ-014 c_ack and d_ack SHALL never be high together; rdata SHALL be held until the next capture; after a write, rdata SHALL be the memory contents at the write address during ACCESS.
REQ-015 Simultaneous requests SHALL be arbitrated per REQ-018/019; a lone request SHALL always be granted.

Reset
REQ-016 rst SHALL asynchronously force state IDLE, c_ack=0, d_ack=0, rdata=0, mem_addr=0, mem_din=0, mem_we=0, starvation counter=0 and last-grant=debug.
REQ-017 Reset during ACCESS or RESP SHALL drop the transaction with no ack; mem_we SHALL fall immediately, without waiting for a clock edge.

Configuration
REQ-018 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL alternate, granting the port not granted last; last-grant updates on every grant; the counter is absent.
REQ-019 Without DMEM_ARB_RR_EN, CPU SHALL win simultaneous requests except when the counter equals HOLD_MAX; then debug wins. The counter increments on each CPU grant while d_req is high and clears on any debug grant or when d_req is low.

Structure
REQ-020 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_CPU/OWN_DBG) and the default width constants.
REQ-021 Grant selection, last-grant and the counter SHALL live in one sub-module, dmem_arb_select; the FSM and datapath registers stay in dmem_arbiter.

Verification
REQ-022 CPU write: c_req=1, c_we=1, c_addr=0x1F, c_wdata=0x07 -> mem_we high one cycle with addr 0x1F/din 0x07; c_ack in cycle N+2; d_ack stays 0.
REQ-023 CPU read-back: after REQ-022, CPU read of 0x1F -> rdata=0x07 with c_ack; c_stall high for cycles N and N+1 only.
REQ-024 Contention, fixed mode, HOLD_MAX=4, both req held high -> grant order C,C,C,C,D,C,C,C,C,D; no more than 4 consecutive C grants.
REQ-025 Contention with DMEM_ARB_RR_EN -> order C,D,C,D starting with CPU after reset.
REQ-026 rst asserted in ACCESS of a debug write to 0xFF -> mem_we falls immediately; no d_ack; state IDLE; memory at 0xFF unchanged when rst rises before the ACCESS edge.
REQ-027 d_req dropped during ACCESS -> transaction completes and d_ack still pulses once.
